spell_mem_banked: RTL and testbench

Parametrised DFF-backed memory for the spell core, successor to the fixed 32-byte code / 8-byte data store. Width, code/data depths and access latency are configurable. Adds an error flag for illegal accesses in place of X propagation, a byte-write mask for WIDTH>8, and a fixed-latency select/ready handshake. Sits between the spell CPU memory interface and the top-level wrapper.

---
 rtl/spell_pkg.sv | 19 +
 rtl/spell_mem_bank.sv | 48 ++++
 rtl/spell_mem_banked.sv | 132 +++++++++++++
 tb/tb_spell_mem_banked.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spell_pkg.sv
// Shared definitions for the spell core memory subsystem.
package spell_pkg;

    // Encodings match what the spell CPU already drives on its memory interface.
    // MemoryTypeIllegal names the whole 2'b1x range; any code with bit 1 set is illegal.
    typedef enum logic [1:0] {
        MemoryTypeData    = 2'b00,
        MemoryTypeCode    = 2'b01,
        MemoryTypeIllegal = 2'b10
    } memory_type_e;

    localparam int unsigned ByteW = 8;

    // Number of byte lanes in a word of the given width.
    function automatic int unsigned num_lanes(input int unsigned width);
        return width / ByteW;
    endfunction

endpackage

// File: rtl/spell_mem_bank.sv
// Single DFF-backed word array: byte-enabled synchronous write, async clear,
// combinational read and an address range flag.
module spell_mem_bank
    import spell_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [WIDTH/8-1:0]    i_byte_en,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_in_range
);

    localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NumBytes = num_lanes(WIDTH);
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IdxW-1:0]  w_idx;

    assign w_idx      = i_addr[IdxW-1:0];
    assign o_in_range = ({1'b0, i_addr} < DepthLim);
    // Out-of-range reads return 0 rather than indexing past the array.
    assign o_rdata    = o_in_range ? r_mem[w_idx] : '0;

    // Clear on reset; otherwise update only the enabled byte lanes of an in-range word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && o_in_range) begin
            for (int b = 0; b < int'(NumBytes); b++) begin
                if (i_byte_en[b]) begin
                    r_mem[w_idx][b*ByteW +: ByteW] <= i_wdata[b*ByteW +: ByteW];
                end
            end
        end
    end

endmodule

// File: rtl/spell_mem_banked.sv
// Code/data memory for the spell core with a fixed-latency select/ready
// handshake and an error flag for out-of-range or illegal-type accesses.
// WIDTH must be a multiple of 8, depths must not exceed 2**ADDR_WIDTH, LATENCY >= 1.
module spell_mem_banked
    import spell_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CODE_DEPTH = 32,
    parameter int unsigned DATA_DEPTH = 8,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  select,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      data_in,
    input  logic [WIDTH/8-1:0]    byte_en,
    input  logic [1:0]            memory_type,
    input  logic                  write,
    output logic [WIDTH-1:0]      data_out,
    output logic                  data_ready,
    output logic                  error
);

    localparam int unsigned      CntW      = $clog2(LATENCY + 1);
    localparam logic [CntW-1:0]  CntReload = CntW'(LATENCY - 1);

    logic [CntW-1:0]  r_cnt;
    logic             r_ready;
    logic             r_error;
    logic [WIDTH-1:0] r_data_out;

    logic [CntW-1:0]  w_cnt_d;
    logic             w_ready_d;
    logic             w_error_d;
    logic [WIDTH-1:0] w_data_out_d;

    logic             w_is_code;
    logic             w_is_data;
    logic             w_code_in_range;
    logic             w_data_in_range;
    logic [WIDTH-1:0] w_code_rdata;
    logic [WIDTH-1:0] w_data_rdata;
    logic [WIDTH-1:0] w_rdata;
    logic             w_illegal;
    logic             w_complete;
    logic             w_code_we;
    logic             w_data_we;

    assign w_is_code = (memory_type == MemoryTypeCode);
    assign w_is_data = (memory_type == MemoryTypeData);
    assign w_rdata   = w_is_code ? w_code_rdata : w_data_rdata;
    assign w_illegal = w_is_code ? !w_code_in_range :
                       (w_is_data ? !w_data_in_range : 1'b1);

    // The access fires exactly once: on the first edge with the countdown expired.
    assign w_complete = select && (r_cnt == '0) && !r_ready;
    assign w_code_we  = w_complete && write && w_is_code;
    assign w_data_we  = w_complete && write && w_is_data;

    spell_mem_bank #(
        .DEPTH      (CODE_DEPTH),
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_code_bank (
        .clock      (clock),
        .reset      (reset),
        .i_we       (w_code_we),
        .i_addr     (addr),
        .i_wdata    (data_in),
        .i_byte_en  (byte_en),
        .o_rdata    (w_code_rdata),
        .o_in_range (w_code_in_range)
    );

    spell_mem_bank #(
        .DEPTH      (DATA_DEPTH),
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_data_bank (
        .clock      (clock),
        .reset      (reset),
        .i_we       (w_data_we),
        .i_addr     (addr),
        .i_wdata    (data_in),
        .i_byte_en  (byte_en),
        .o_rdata    (w_data_rdata),
        .o_in_range (w_data_in_range)
    );

    // Handshake next state: reload while idle, count down, then complete once and hold.
    always_comb begin
        w_cnt_d      = r_cnt;
        w_ready_d    = r_ready;
        w_error_d    = r_error;
        w_data_out_d = r_data_out;
        if (!select) begin
            w_cnt_d   = CntReload;
            w_ready_d = 1'b0;
            w_error_d = 1'b0;
        end else if (r_cnt != '0) begin
            w_cnt_d = r_cnt - CntW'(1);
        end else if (!r_ready) begin
            w_ready_d = 1'b1;
            w_error_d = w_illegal;
            if (!write) begin
                w_data_out_d = w_illegal ? '0 : w_rdata;
            end
        end
    end

    // Handshake state register with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt      <= CntReload;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_cnt      <= w_cnt_d;
            r_ready    <= w_ready_d;
            r_error    <= w_error_d;
            r_data_out <= w_data_out_d;
        end
    end

    assign data_out   = r_data_out;
    assign data_ready = r_ready;
    assign error      = r_error;

endmodule

// File: tb/tb_spell_mem_banked.sv
// Bench for spell_mem_banked: a default instance (8-bit, latency 4) and a
// 16-bit latency-1 instance, checked against a behavioural array model.
module tb_spell_mem_banked;

    logic        clk;
    logic        rst_n;

    logic        s0_sel, s0_wr;
    logic [7:0]  s0_addr, s0_din;
    logic [0:0]  s0_be;
    logic [1:0]  s0_type;
    logic [7:0]  s0_dout;
    logic        s0_rdy, s0_err;

    logic        s1_sel, s1_wr;
    logic [7:0]  s1_addr;
    logic [15:0] s1_din;
    logic [1:0]  s1_be;
    logic [1:0]  s1_type;
    logic [15:0] s1_dout;
    logic        s1_rdy, s1_err;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: memory contents and last data_out per instance.
    logic [15:0] mcode  [2][32];
    logic [15:0] mdata  [2][8];
    logic [15:0] dout_m [2];

    spell_mem_banked u_d8 (
        .clock       (clk),
        .reset       (rst_n),
        .select      (s0_sel),
        .addr        (s0_addr),
        .data_in     (s0_din),
        .byte_en     (s0_be),
        .memory_type (s0_type),
        .write       (s0_wr),
        .data_out    (s0_dout),
        .data_ready  (s0_rdy),
        .error       (s0_err)
    );

    spell_mem_banked #(
        .WIDTH   (16),
        .LATENCY (1)
    ) u_d16 (
        .clock       (clk),
        .reset       (rst_n),
        .select      (s1_sel),
        .addr        (s1_addr),
        .data_in     (s1_din),
        .byte_en     (s1_be),
        .memory_type (s1_type),
        .write       (s1_wr),
        .data_out    (s1_dout),
        .data_ready  (s1_rdy),
        .error       (s1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic obs_rdy(input int dut);
        return (dut == 0) ? s0_rdy : s1_rdy;
    endfunction

    function automatic logic obs_err(input int dut);
        return (dut == 0) ? s0_err : s1_err;
    endfunction

    function automatic logic [15:0] obs_dout(input int dut);
        return (dut == 0) ? {8'h00, s0_dout} : s1_dout;
    endfunction

    task automatic set_sel(input int dut, input logic v);
        if (dut == 0) s0_sel = v;
        else          s1_sel = v;
    endtask

    task automatic drive(input int dut, input logic [1:0] t, input logic [7:0] a, input logic w,
                         input logic [15:0] d, input logic [1:0] be);
        if (dut == 0) begin
            s0_type = t; s0_addr = a; s0_wr = w; s0_din = d[7:0]; s0_be = be[0:0];
        end else begin
            s1_type = t; s1_addr = a; s1_wr = w; s1_din = d; s1_be = be;
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) mcode[k][i] = '0;
            for (int i = 0; i < 8; i++)  mdata[k][i] = '0;
            dout_m[k] = '0;
        end
    endtask

    // One complete access: junk inputs until the completing edge, then real ones;
    // check latency and results, hold select for 'hold' extra edges, then drop it.
    task automatic acc(input int dut, input logic [1:0] t, input logic [7:0] a, input logic w,
                       input logic [15:0] d, input logic [1:0] be, input int hold,
                       input string tag);
        int lat;
        int edges;
        bit done;
        logic ill;
        logic [15:0] exp_d;
        lat = (dut == 0) ? 4 : 1;
        if (dut == 0) begin
            d[15:8] = 8'h00;
            be[1]   = 1'b0;
        end
        ill = t[1] || (t == 2'b00 && a >= 8) || (t == 2'b01 && a >= 32);
        exp_d = dout_m[dut];
        if (!w) begin
            if (ill)          exp_d = '0;
            else if (t[0])    exp_d = mcode[dut][a[4:0]];
            else              exp_d = mdata[dut][a[2:0]];
        end else if (!ill) begin
            for (int b = 0; b < 2; b++) begin
                if (be[b]) begin
                    if (t[0]) mcode[dut][a[4:0]][8*b +: 8] = d[8*b +: 8];
                    else      mdata[dut][a[2:0]][8*b +: 8] = d[8*b +: 8];
                end
            end
        end
        dout_m[dut] = exp_d;

        @(negedge clk);
        set_sel(dut, 1'b1);
        if (lat > 1) drive(dut, 2'($urandom), 8'($urandom), 1'($urandom), 16'($urandom),
                           2'($urandom));
        else         drive(dut, t, a, w, d, be);
        edges = 0;
        done  = 1'b0;
        while (!done && edges < 4 * lat + 8) begin
            @(posedge clk);
            edges++;
            #1;
            if (obs_rdy(dut)) begin
                done = 1'b1;
            end else if (edges == lat - 1) begin
                @(negedge clk);
                drive(dut, t, a, w, d, be);
            end
        end
        chk({tag, ":latency"}, edges, lat);
        chk({tag, ":ready"}, {31'd0, obs_rdy(dut)}, 1);
        chk({tag, ":error"}, {31'd0, obs_err(dut)}, {31'd0, ill});
        chk({tag, ":data_out"}, {16'd0, obs_dout(dut)}, {16'd0, exp_d});

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            drive(dut, t, a ^ 8'h01, w, ~d, 2'b11);
            @(posedge clk);
            #1;
            chk({tag, ":hold_ready"}, {31'd0, obs_rdy(dut)}, 1);
            chk({tag, ":hold_error"}, {31'd0, obs_err(dut)}, {31'd0, ill});
            chk({tag, ":hold_data"}, {16'd0, obs_dout(dut)}, {16'd0, exp_d});
        end

        @(negedge clk);
        set_sel(dut, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, ":idle_ready"}, {31'd0, obs_rdy(dut)}, 0);
        chk({tag, ":idle_error"}, {31'd0, obs_err(dut)}, 0);
        chk({tag, ":idle_data"}, {16'd0, obs_dout(dut)}, {16'd0, exp_d});
    endtask

    initial begin
        logic [1:0] t;
        logic [7:0] a;
        rst_n  = 1'b0;
        s0_sel = 1'b0; s1_sel = 1'b0;
        drive(0, 2'b00, 8'd0, 1'b0, 16'd0, 2'b00);
        drive(1, 2'b00, 8'd0, 1'b0, 16'd0, 2'b00);
        clear_model();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, s0_rdy}, 0);
        chk("rst_error", {31'd0, s0_err}, 0);
        chk("rst_data", {24'd0, s0_dout}, 0);
        chk("rst_data16", {16'd0, s1_dout}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back Code 5.
        acc(0, 2'b01, 8'd5, 1'b1, 16'h00A5, 2'b01, 0, "t1_write");
        acc(0, 2'b01, 8'd5, 1'b0, 16'h0000, 2'b01, 0, "t1_read");
        chk("t1_value", {24'd0, s0_dout}, 32'hA5);

        // Out-of-range accesses.
        acc(0, 2'b00, 8'd8, 1'b0, 16'h0000, 2'b01, 0, "t2_read_oor");
        acc(0, 2'b00, 8'd200, 1'b1, 16'h00FF, 2'b01, 0, "t2_write_oor");
        for (int i = 0; i < 8; i++) acc(0, 2'b00, 8'(i), 1'b0, 16'h0, 2'b01, 0, "t2_scan");

        // Illegal memory types.
        acc(0, 2'b10, 8'd1, 1'b0, 16'h0, 2'b01, 0, "t3_type10");
        chk("t3_noX", {31'd0, $isunknown({s0_dout, s0_rdy, s0_err})}, 0);
        acc(0, 2'b11, 8'd5, 1'b1, 16'h0077, 2'b01, 0, "t3_type11_write");
        acc(0, 2'b01, 8'd5, 1'b0, 16'h0, 2'b01, 0, "t3_code5_intact");

        // Byte lanes on the 16-bit latency-1 instance.
        acc(1, 2'b00, 8'd3, 1'b1, 16'h1234, 2'b11, 0, "t4_w_full");
        acc(1, 2'b00, 8'd3, 1'b1, 16'hFFFF, 2'b10, 0, "t4_w_hi");
        acc(1, 2'b00, 8'd3, 1'b0, 16'h0, 2'b00, 0, "t4_read");
        chk("t4_value", {16'd0, s1_dout}, 32'hFF34);

        // Hold select after ready: exactly one write, outputs frozen.
        acc(0, 2'b00, 8'd2, 1'b1, 16'h005A, 2'b01, 10, "t5_hold_write");
        acc(0, 2'b00, 8'd3, 1'b0, 16'h0, 2'b01, 0, "t5_neighbour");
        acc(0, 2'b00, 8'd2, 1'b0, 16'h0, 2'b01, 10, "t5_hold_read");
        acc(1, 2'b01, 8'd7, 1'b1, 16'hBEEF, 2'b11, 5, "t5_hold16");
        acc(1, 2'b01, 8'd7, 1'b0, 16'h0, 2'b11, 0, "t5_read16");

        // Reset in the middle of a Code write.
        acc(0, 2'b01, 8'd5, 1'b0, 16'h0, 2'b01, 0, "t6_pre_read");
        @(negedge clk);
        s0_sel = 1'b1;
        drive(0, 2'b01, 8'd9, 1'b1, 16'h003C, 2'b01);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        chk("t6_ready", {31'd0, s0_rdy}, 0);
        chk("t6_error", {31'd0, s0_err}, 0);
        chk("t6_data", {24'd0, s0_dout}, 0);
        chk("t6_data16", {16'd0, s1_dout}, 0);
        @(negedge clk);
        s0_sel = 1'b0;
        rst_n  = 1'b1;
        acc(0, 2'b01, 8'd9, 1'b0, 16'h0, 2'b01, 0, "t6_read9");
        acc(0, 2'b01, 8'd5, 1'b0, 16'h0, 2'b01, 0, "t6_read5");

        // Randomised traffic on both instances.
        for (int i = 0; i < 80; i++) begin
            int dut;
            dut = int'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) t = 2'($urandom_range(2, 3));
            else                           t = 2'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 8'($urandom);
            else                           a = 8'($urandom_range(0, (t == 2'b01) ? 31 : 7));
            acc(dut, t, a, 1'($urandom), 16'($urandom), 2'($urandom),
                int'($urandom_range(0, 2)), "rand");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
